mem_write_checker: RTL and testbench

Synthesizable, parametrised self-check monitor for the processor's data-memory write port. It holds a programmable table of expected (address, data) stores and a list of ignorable addresses. While armed, it checks every store the core issues against the table in order. It reports pass, fail, a failure cause and a timeout, so the same check can run in simulation or on silicon/FPGA instead of a `$display`/`$stop` bench.

---
 rtl/mem_write_checker.sv | 170 +++++++++++++++++
 tb/tb_mem_write_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Self-check monitor for the data-memory write port: compares core stores against
// a programmable table of expected (address, data) pairs and reports a verdict.
module mem_write_checker #(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 8,
    parameter  int NIGNORE = 2,
    parameter  int TIMEOUT = 1024,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW      = $clog2(DEPTH + 1),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] data_adr,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [IW-1:0]    fail_index,
    output logic [CW-1:0]    write_count,
    output logic [CW-1:0]    cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, PASS_S, FAIL_S} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] exp_addr [DEPTH];
    logic [WIDTH-1:0] exp_data [DEPTH];
    logic [WIDTH-1:0] ign_addr [NIGNORE];
    logic             ign_vld  [NIGNORE];
    logic [IW-1:0]    ptr;
    logic [LW-1:0]    len_q;

    logic [WIDTH-1:0] cur_addr, cur_data;
    logic             ign_hit, addr_eq, data_eq, is_last, len_ok, timeout_hit;
    logic             do_match, do_pass, do_fail;
    logic [1:0]       next_code;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Loop-based muxes keep index widths matched for any DEPTH/NIGNORE
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(ptr) == i) begin
                cur_addr = exp_addr[i];
                cur_data = exp_data[i];
            end
        end
        ign_hit = 1'b0;
        for (int i = 0; i < NIGNORE; i++) begin
            if (ign_vld[i] && ign_addr[i] == data_adr) ign_hit = 1'b1;
        end
    end

    assign addr_eq     = (data_adr == cur_addr);
    assign data_eq     = (write_data == cur_data);
    assign is_last     = ((LW'(ptr) + LW'(1)) == len_q);
    assign len_ok      = (len != '0) && (len <= LW'(DEPTH));
    assign timeout_hit = (cycle_count == CW'(TIMEOUT - 1));
    assign busy        = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // A match wins over the timeout; any mismatch reports its own cause, not timeout
    always_comb begin
        next_state = state;
        do_match   = 1'b0;
        do_pass    = 1'b0;
        do_fail    = 1'b0;
        next_code  = 2'd0;
        case (state)
            RUN: begin
                if (mem_write) begin
                    if (addr_eq && data_eq) begin
                        do_match = 1'b1;
                        do_pass  = is_last;
                    end else if (!ign_hit) begin
                        do_fail   = 1'b1;
                        next_code = addr_eq ? 2'd2 : 2'd1;
                    end
                end
                if (!do_pass && !do_fail && timeout_hit) begin
                    do_fail   = 1'b1;
                    next_code = 2'd3;
                end
                if (do_pass)      next_state = PASS_S;
                else if (do_fail) next_state = FAIL_S;
            end
            default: begin
                if (start && len_ok) next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_addr[i] <= '0;
                exp_data[i] <= '0;
            end
            for (int i = 0; i < NIGNORE; i++) begin
                ign_addr[i] <= '0;
                ign_vld[i]  <= 1'b0;
            end
            ptr         <= '0;
            len_q       <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 2'd0;
            fail_index  <= '0;
            write_count <= '0;
            cycle_count <= '0;
        end else begin
            if (cfg_we && state != RUN) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!cfg_sel && int'(cfg_idx) == i) begin
                        exp_addr[i] <= cfg_addr;
                        exp_data[i] <= cfg_data;
                    end
                end
                for (int i = 0; i < NIGNORE; i++) begin
                    if (cfg_sel && int'(cfg_idx) == i) begin
                        ign_addr[i] <= cfg_addr;
                        ign_vld[i]  <= cfg_data[0];
                    end
                end
            end
            if (state != RUN && next_state == RUN) begin
                len_q       <= len;
                ptr         <= '0;
                pass        <= 1'b0;
                fail        <= 1'b0;
                fail_code   <= 2'd0;
                fail_index  <= '0;
                write_count <= '0;
                cycle_count <= '0;
            end
            if (state == RUN) begin
                if (mem_write)  write_count <= sat_inc(write_count);
                if (do_match)   ptr <= ptr + 1'b1;
                // The deciding edge leaves cycle_count at the last RUN value
                if (next_state == RUN) cycle_count <= sat_inc(cycle_count);
                if (do_pass)    pass <= 1'b1;
                if (do_fail) begin
                    fail       <= 1'b1;
                    fail_code  <= next_code;
                    fail_index <= ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: table programming, pass/fail causes,
// timeout boundary, mid-run reset and ignored start/config during a run.
module tb_mem_write_checker;

    localparam int WIDTH = 32;
    localparam int IW    = 3;
    localparam int LW    = 4;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic             cfg_sel = 1'b0;
    logic [IW-1:0]    cfg_idx = '0;
    logic [WIDTH-1:0] cfg_addr = '0;
    logic [WIDTH-1:0] cfg_data = '0;
    logic             start = 1'b0;
    logic [LW-1:0]    len = '0;
    logic             mem_write = 1'b0;
    logic [WIDTH-1:0] data_adr = '0;
    logic [WIDTH-1:0] write_data = '0;
    logic             busy, pass, fail;
    logic [1:0]       fail_code;
    logic [IW-1:0]    fail_index;
    logic [CW-1:0]    write_count, cycle_count;

    int vectors = 0;
    int miscompares = 0;

    mem_write_checker #(.WIDTH(32), .DEPTH(8), .NIGNORE(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .len(len),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_index(fail_index), .write_count(write_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input int idx, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_idx  = IW'(idx);
        cfg_addr = WIDTH'(addr);
        cfg_data = WIDTH'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = LW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic store(input int addr, input int data);
        mem_write  = 1'b1;
        data_adr   = WIDTH'(addr);
        write_data = WIDTH'(data);
        tick();
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({busy, pass, fail, fail_code} !== 5'b0) begin
            $display("FAIL reset_flags: got busy=%b pass=%b fail=%b code=%0d required all 0", busy, pass, fail, fail_code);
            miscompares++;
        end
        vectors++;
        if (write_count !== 0 || cycle_count !== 0 || fail_index !== 0) begin
            $display("FAIL reset_counts: got wc=%0d cc=%0d idx=%0d required 0", write_count, cycle_count, fail_index);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_pass();
        cfg_write(1'b0, 0, 248, 7);
        cfg_write(1'b1, 0, 236, 1);
        do_start(1);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy: got %b required 1", busy);
            miscompares++;
        end
        store(236, 0);
        vectors++;
        if (busy !== 1'b1 || pass !== 1'b0 || fail !== 1'b0) begin
            $display("FAIL basic_ignored: got busy=%b pass=%b fail=%b required 1/0/0", busy, pass, fail);
            miscompares++;
        end
        store(248, 7);
        vectors++;
        if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_pass: got pass=%b fail=%b busy=%b required 1/0/0", pass, fail, busy);
            miscompares++;
        end
        vectors++;
        if (write_count !== 5'd2) begin
            $display("FAIL basic_wcount: got %0d required 2", write_count);
            miscompares++;
        end
    endtask

    task automatic test_mismatch();
        do_start(1);
        vectors++;
        if (pass !== 1'b0) begin
            $display("FAIL restart_clears: got pass=%b required 0", pass);
            miscompares++;
        end
        store(248, 6);
        vectors++;
        if (fail !== 1'b1 || pass !== 1'b0 || fail_code !== 2'd2 || fail_index !== 3'd0) begin
            $display("FAIL data_mismatch: got fail=%b pass=%b code=%0d idx=%0d required 1/0/2/0", fail, pass, fail_code, fail_index);
            miscompares++;
        end
        do_start(1);
        store(100, 7);
        vectors++;
        if (fail !== 1'b1 || fail_code !== 2'd1) begin
            $display("FAIL bad_address: got fail=%b code=%0d required 1/1", fail, fail_code);
            miscompares++;
        end
    endtask

    task automatic test_multi();
        cfg_write(1'b0, 0, 4, 1);
        cfg_write(1'b0, 1, 8, 2);
        cfg_write(1'b0, 2, 12, 3);
        do_start(3);
        store(4, 1);
        store(236, 0);
        store(8, 2);
        store(236, 0);
        vectors++;
        if (busy !== 1'b1 || pass !== 1'b0) begin
            $display("FAIL multi_midrun: got busy=%b pass=%b required 1/0", busy, pass);
            miscompares++;
        end
        store(12, 3);
        vectors++;
        if (pass !== 1'b1 || fail !== 1'b0 || write_count !== 5'd5) begin
            $display("FAIL multi_pass: got pass=%b fail=%b wc=%0d required 1/0/5", pass, fail, write_count);
            miscompares++;
        end
        do_start(3);
        store(8, 2);
        vectors++;
        if (fail !== 1'b1 || fail_code !== 2'd1 || fail_index !== 3'd0) begin
            $display("FAIL out_of_order: got fail=%b code=%0d idx=%0d required 1/1/0", fail, fail_code, fail_index);
            miscompares++;
        end
        do_start(3);
        store(4, 1);
        store(8, 9);
        vectors++;
        if (fail !== 1'b1 || fail_code !== 2'd2 || fail_index !== 3'd1) begin
            $display("FAIL second_entry: got fail=%b code=%0d idx=%0d required 1/2/1", fail, fail_code, fail_index);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        do_start(1);
        repeat (15) tick();
        vectors++;
        if (fail !== 1'b0 || busy !== 1'b1 || cycle_count !== 5'd15) begin
            $display("FAIL before_timeout: got fail=%b busy=%b cc=%0d required 0/1/15", fail, busy, cycle_count);
            miscompares++;
        end
        tick();
        vectors++;
        if (fail !== 1'b1 || fail_code !== 2'd3 || cycle_count !== 5'd15 || busy !== 1'b0) begin
            $display("FAIL timeout: got fail=%b code=%0d cc=%0d busy=%b required 1/3/15/0", fail, fail_code, cycle_count, busy);
            miscompares++;
        end
        do_start(1);
        repeat (15) tick();
        store(4, 1);
        vectors++;
        if (pass !== 1'b1 || fail !== 1'b0) begin
            $display("FAIL match_on_timeout: got pass=%b fail=%b required 1/0", pass, fail);
            miscompares++;
        end
        do_start(1);
        repeat (15) tick();
        store(100, 0);
        vectors++;
        if (fail !== 1'b1 || fail_code !== 2'd1) begin
            $display("FAIL mismatch_on_timeout: got fail=%b code=%0d required 1/1", fail, fail_code);
            miscompares++;
        end
    endtask

    task automatic test_reset_midrun();
        do_start(3);
        store(4, 1);
        reset = 1'b0;
        #2;
        vectors++;
        if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || write_count !== 0 || cycle_count !== 0) begin
            $display("FAIL midrun_reset: got busy=%b pass=%b fail=%b wc=%0d cc=%0d required all 0", busy, pass, fail, write_count, cycle_count);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        cfg_write(1'b0, 0, 248, 7);
        do_start(1);
        store(236, 0);
        vectors++;
        if (fail !== 1'b1 || fail_code !== 2'd1) begin
            $display("FAIL ignore_cleared: got fail=%b code=%0d required 1/1", fail, fail_code);
            miscompares++;
        end
        cfg_write(1'b1, 0, 236, 1);
        do_start(1);
        store(236, 0);
        store(248, 7);
        vectors++;
        if (pass !== 1'b1 || write_count !== 5'd2) begin
            $display("FAIL rerun_after_reset: got pass=%b wc=%0d required 1/2", pass, write_count);
            miscompares++;
        end
    endtask

    task automatic test_start_and_cfg_ignored();
        do_start(0);
        vectors++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            $display("FAIL start_len0: got busy=%b pass=%b required 0/1", busy, pass);
            miscompares++;
        end
        do_start(9);
        vectors++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            $display("FAIL start_len9: got busy=%b pass=%b required 0/1", busy, pass);
            miscompares++;
        end
        cfg_write(1'b0, 1, 16, 5);
        do_start(2);
        store(248, 7);
        do_start(1);
        cfg_write(1'b0, 1, 20, 9);
        vectors++;
        if (busy !== 1'b1 || write_count !== 5'd1) begin
            $display("FAIL start_in_run: got busy=%b wc=%0d required 1/1", busy, write_count);
            miscompares++;
        end
        store(16, 5);
        vectors++;
        if (pass !== 1'b1 || write_count !== 5'd2) begin
            $display("FAIL run_after_ignored: got pass=%b wc=%0d required 1/2", pass, write_count);
            miscompares++;
        end
        do_start(2);
        store(248, 7);
        store(16, 5);
        vectors++;
        if (pass !== 1'b1 || fail !== 1'b0) begin
            $display("FAIL cfg_in_run: got pass=%b fail=%b code=%0d required 1/0", pass, fail, fail_code);
            miscompares++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_pass();
        test_mismatch();
        test_multi();
        test_timeout();
        test_reset_midrun();
        test_start_and_cfg_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
